// File: rtl/trace_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_pkg : kind/state encodings and trace record layout              |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package trace_pkg;

    typedef enum logic [2:0] {
        KIND_ALU  = 3'd0,
        KIND_LD   = 3'd1,
        KIND_ST   = 3'd2,
        KIND_STU  = 3'd3,
        KIND_NOP  = 3'd4,
        KIND_HALT = 3'd5
    } kind_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam int KIND_W  = 3;
    localparam int OFF_REG = 0;

    // Record layout, LSB first: reg, mdata, addr, rdata, pc, inum, kind.
    function automatic int off_mdata(input int reg_w);
        return reg_w;
    endfunction

    function automatic int off_addr(input int reg_w, input int data_w);
        return reg_w + data_w;
    endfunction

    function automatic int off_rdata(input int reg_w, input int data_w);
        return reg_w + 2 * data_w;
    endfunction

    function automatic int off_pc(input int reg_w, input int data_w);
        return reg_w + 3 * data_w;
    endfunction

    function automatic int off_inum(input int reg_w, input int data_w);
        return reg_w + 4 * data_w;
    endfunction

    function automatic int off_kind(input int reg_w, input int data_w, input int cnt_w);
        return reg_w + 4 * data_w + cnt_w;
    endfunction

    function automatic int rec_width(input int reg_w, input int data_w, input int cnt_w);
        return reg_w + 4 * data_w + cnt_w + KIND_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_fifo : record FIFO with wrap-bit pointers and tail overwrite    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             overwrite,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic             do_ovw;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    always_comb begin
        do_pop    = pop && !empty;
        do_push   = push && (!full || do_pop);
        // Overwrite replaces the newest entry without moving any pointer.
        do_ovw    = overwrite && full && !do_pop;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        mem_we    = do_push || do_ovw;
        mem_waddr = do_push ? wr_ptr_q[AW-1:0] : (wr_ptr_q[AW-1:0] - AW'(1));
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= wdata;
        end
    end

    assign valid = !empty;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/trace_commit_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_commit_monitor : classifies, numbers and buffers commit records |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module trace_commit_monitor #(
    parameter int DATA_W     = 16,
    parameter int REG_W      = 3,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = 32,
    parameter bit TRACE_NOPS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              commit_valid,
    input  logic [DATA_W-1:0] commit_pc,
    input  logic              reg_write,
    input  logic [REG_W-1:0]  write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              halt,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [2:0]        rec_kind,
    output logic [CNT_W-1:0]  rec_inum,
    output logic [DATA_W-1:0] rec_pc,
    output logic [DATA_W-1:0] rec_rdata,
    output logic [DATA_W-1:0] rec_addr,
    output logic [DATA_W-1:0] rec_mdata,
    output logic [REG_W-1:0]  rec_reg,
    output logic [CNT_W-1:0]  inst_count,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              overflow,
    output logic              done
);
    import trace_pkg::*;

    localparam int REC_W     = rec_width(REG_W, DATA_W, CNT_W);
    localparam int OFF_MDATA = off_mdata(REG_W);
    localparam int OFF_ADDR  = off_addr(REG_W, DATA_W);
    localparam int OFF_RDATA = off_rdata(REG_W, DATA_W);
    localparam int OFF_PC    = off_pc(REG_W, DATA_W);
    localparam int OFF_INUM  = off_inum(REG_W, DATA_W);
    localparam int OFF_KIND  = off_kind(REG_W, DATA_W, CNT_W);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  inst_count_q, inst_count_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0]  drop_count_q, drop_count_d;
    logic              overflow_q, overflow_d;
    kind_e             kind;
    logic              accept;
    logic              emit;
    logic              fifo_pop;
    logic              fifo_full;
    logic              drop;
    logic [REC_W-1:0]  push_rec;
    logic [REC_W-1:0]  head_rec;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        kind = KIND_NOP;
        if (reg_write && mem_write)     kind = KIND_STU;
        else if (reg_write && mem_read) kind = KIND_LD;
        else if (reg_write)             kind = KIND_ALU;
        else if (halt)                  kind = KIND_HALT;
        else if (mem_write)             kind = KIND_ST;
    end

    always_comb begin
        push_rec = '0;
        push_rec[OFF_KIND +: KIND_W] = kind;
        push_rec[OFF_INUM +: CNT_W]  = inst_count_q;
        push_rec[OFF_PC +: DATA_W]   = commit_pc;
        if (kind inside {KIND_ALU, KIND_LD, KIND_STU}) begin
            push_rec[OFF_RDATA +: DATA_W] = write_data;
            push_rec[OFF_REG +: REG_W]    = write_reg;
        end
        if (kind inside {KIND_LD, KIND_ST, KIND_STU}) begin
            push_rec[OFF_ADDR +: DATA_W] = mem_addr;
        end
        if (kind inside {KIND_ST, KIND_STU}) begin
            push_rec[OFF_MDATA +: DATA_W] = mem_data;
        end
    end

    assign accept   = commit_valid && (state_q == ST_RUN);
    assign emit     = accept && (TRACE_NOPS || (kind != KIND_NOP));
    assign fifo_pop = rec_valid && rec_ready;
    // A HALT into a full FIFO still costs one record: the one it replaces.
    assign drop     = emit && fifo_full && !fifo_pop;

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (emit),
        .pop       (fifo_pop),
        .overwrite (emit && (kind == KIND_HALT)),
        .wdata     (push_rec),
        .rdata     (head_rec),
        .valid     (rec_valid),
        .full      (fifo_full)
    );

    always_comb begin
        state_d       = state_q;
        inst_count_d  = inst_count_q;
        cycle_count_d = cycle_count_q;
        drop_count_d  = drop_count_q;
        overflow_d    = overflow_q;
        if (accept) begin
            inst_count_d = sat_inc(inst_count_q);
        end
        if (state_q != ST_DONE) begin
            cycle_count_d = sat_inc(cycle_count_q);
        end
        if (drop) begin
            drop_count_d = sat_inc(drop_count_q);
            overflow_d   = 1'b1;
        end
        case (state_q)
            ST_RUN: begin
                if (accept && (kind == KIND_HALT)) state_d = ST_HALTED;
            end
            ST_HALTED: begin
                if (fifo_pop && (head_rec[OFF_KIND +: KIND_W] == KIND_HALT)) state_d = ST_DONE;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            inst_count_q  <= '0;
            cycle_count_q <= '0;
            drop_count_q  <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            inst_count_q  <= inst_count_d;
            cycle_count_q <= cycle_count_d;
            drop_count_q  <= drop_count_d;
            overflow_q    <= overflow_d;
        end
    end

    assign rec_kind    = head_rec[OFF_KIND +: KIND_W];
    assign rec_inum    = head_rec[OFF_INUM +: CNT_W];
    assign rec_pc      = head_rec[OFF_PC +: DATA_W];
    assign rec_rdata   = head_rec[OFF_RDATA +: DATA_W];
    assign rec_addr    = head_rec[OFF_ADDR +: DATA_W];
    assign rec_mdata   = head_rec[OFF_MDATA +: DATA_W];
    assign rec_reg     = head_rec[OFF_REG +: REG_W];
    assign inst_count  = inst_count_q;
    assign cycle_count = cycle_count_q;
    assign drop_count  = drop_count_q;
    assign overflow    = overflow_q;
    assign done        = (state_q == ST_DONE);

endmodule
`default_nettype wire
